// File: rtl/iterative_roll_remover_pkg.sv
// iterative_roll_remover_pkg: shared FSM encoding and counter-width helpers
package iterative_roll_remover_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWEEP, S_DONE} state_t;
  function automatic int cw_width(input int w, input int d);
    return $clog2(w * d + 1);
  endfunction
  function automatic int sw_width(input int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/iterative_roll_remover_grid_sweep.sv
// grid_sweep: one simultaneous removal sweep over the whole grid
module grid_sweep import iterative_roll_remover_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int THRESH = 4,
  localparam int CW = cw_width(WIDTH, DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] grid,
  output logic [DEPTH-1:0][WIDTH-1:0] next_grid,
  output logic [CW-1:0]               r
);
  logic [DEPTH+1:0][WIDTH+1:0] pad;
  logic [DEPTH-1:0][WIDTH-1:0] kill;
  // zero border makes out-of-grid neighbours count as empty
  always_comb begin
    pad = '0;
    for (int i = 0; i < DEPTH; i++) pad[i+1][WIDTH:1] = grid[i];
  end
  for (genvar y = 0; y < DEPTH; y++) begin : g_row
    for (genvar x = 0; x < WIDTH; x++) begin : g_col
      logic [3:0] n;
      assign n = 4'(pad[y][x]) + 4'(pad[y][x+1]) + 4'(pad[y][x+2]) +
                 4'(pad[y+1][x]) + 4'(pad[y+1][x+2]) +
                 4'(pad[y+2][x]) + 4'(pad[y+2][x+1]) + 4'(pad[y+2][x+2]);
      assign kill[y][x] = grid[y][x] && (int'(n) < THRESH);
    end
  end
  assign next_grid = grid & ~kill;
  always_comb begin
    r = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < WIDTH; j++) r = r + CW'(kill[i][j]);
  end
endmodule

// File: rtl/iterative_roll_remover.sv
// iterative_roll_remover: loads a grid row by row, then sweeps away sparsely surrounded rolls
module iterative_roll_remover import iterative_roll_remover_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int THRESH = 4,
  parameter int MAX_SWEEPS = WIDTH * DEPTH,
  localparam int CW = cw_width(WIDTH, DEPTH),
  localparam int SW = sw_width(MAX_SWEEPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] row_data,
  input  logic             row_valid,
  output logic             row_ready,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    removed_total,
  output logic [SW-1:0]    sweeps,
  output logic [CW-1:0]    remaining,
  output logic             limit_hit
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_t state, state_d;
  logic mode_q, go, take, last_row, lim, sweep_exit;
  logic [IW-1:0] idx;
  logic [DEPTH-1:0][WIDTH-1:0] grid, grid_nx;
  logic [CW-1:0] r;
  logic [SW-1:0] sweeps_inc;
  grid_sweep #(.WIDTH(WIDTH), .DEPTH(DEPTH), .THRESH(THRESH)) u_sweep (
    .grid(grid), .next_grid(grid_nx), .r(r)
  );
  assign go = start && (state == S_IDLE || state == S_DONE);
  assign take = row_valid && row_ready;
  assign last_row = idx == IW'(DEPTH - 1);
  assign sweeps_inc = sweeps + SW'(1);
  assign lim = r != '0 && sweeps_inc == SW'(MAX_SWEEPS);
  assign sweep_exit = r == '0 || !mode_q || lim;
  always_comb begin
    row_ready = state == S_LOAD;
    busy = state == S_LOAD || state == S_SWEEP;
    done = state == S_DONE;
    state_d = go ? S_LOAD :
              (state == S_LOAD && take && last_row) ? S_SWEEP :
              (state == S_SWEEP && sweep_exit) ? S_DONE : state;
  end
  always_comb begin
    remaining = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < WIDTH; j++) remaining = remaining + CW'(grid[i][j]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mode_q <= 1'b0;
      idx <= '0;
      grid <= '0;
      removed_total <= '0;
      sweeps <= '0;
      limit_hit <= 1'b0;
    end else begin
      state <= state_d;
      if (go) begin
        mode_q <= mode;
        idx <= '0;
        removed_total <= '0;
        sweeps <= '0;
        limit_hit <= 1'b0;
      end
      if (state == S_LOAD && take) begin
        grid[idx] <= row_data;
        idx <= idx + 1'b1;
      end
      if (state == S_SWEEP) begin
        grid <= grid_nx;
        removed_total <= removed_total + r;
        if (r != '0) sweeps <= sweeps_inc;
        if (lim) limit_hit <= 1'b1;
      end
    end
  end
endmodule
